// File: rtl/imuldiv_div_arbiter.sv
// rtl/imuldiv_div_arbiter.sv - two-port val/rdy arbiter sharing one iterative divide unit
//
// Holds one operation at a time. It latches the winning request, issues it to the
// divider, captures the {remainder, quotient} result and returns it to the port
// that owns the operation.
//
// Optional feature macro: IMULDIV_DIV_ARBITER_RR_EN
//   defined   - round-robin arbitration between the two request ports
//   undefined - fixed priority, port 0 always wins over port 1
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   req{0,1}_msg_fn/_a/_b          request function and operands per port
//   req{0,1}_val / req{0,1}_rdy    request handshake per port
//   resp{0,1}_msg_result           result {rem, quot}, qualified by resp{0,1}_val
//   resp{0,1}_val / resp{0,1}_rdy  response handshake per port
//   divreq_msg_fn/_a/_b            latched operation presented to the divider
//   divreq_val / divreq_rdy        divider request handshake
//   divresp_msg_result             divider result
//   divresp_val / divresp_rdy      divider response handshake
module imuldiv_div_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                req0_msg_fn,
    input  logic [DATA_W-1:0]   req0_msg_a,
    input  logic [DATA_W-1:0]   req0_msg_b,
    input  logic                req0_val,
    output logic                req0_rdy,
    output logic [2*DATA_W-1:0] resp0_msg_result,
    output logic                resp0_val,
    input  logic                resp0_rdy,

    input  logic                req1_msg_fn,
    input  logic [DATA_W-1:0]   req1_msg_a,
    input  logic [DATA_W-1:0]   req1_msg_b,
    input  logic                req1_val,
    output logic                req1_rdy,
    output logic [2*DATA_W-1:0] resp1_msg_result,
    output logic                resp1_val,
    input  logic                resp1_rdy,

    output logic                divreq_msg_fn,
    output logic [DATA_W-1:0]   divreq_msg_a,
    output logic [DATA_W-1:0]   divreq_msg_b,
    output logic                divreq_val,
    input  logic                divreq_rdy,
    input  logic [2*DATA_W-1:0] divresp_msg_result,
    input  logic                divresp_val,
    output logic                divresp_rdy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                ptr_q,   ptr_d;
    logic                fn_q,    fn_d;
    logic [DATA_W-1:0]   a_q,     a_d;
    logic [DATA_W-1:0]   b_q,     b_d;
    logic [2*DATA_W-1:0] result_q, result_d;

    logic any_val;
    logic grant;

    // grant = 0 selects port 0, grant = 1 selects port 1
    always_comb begin
        any_val = req0_val | req1_val;
`ifdef IMULDIV_DIV_ARBITER_RR_EN
        // ptr_q records the last owner served, so the other port wins a tie
        if (req0_val && req1_val) begin
            grant = ~ptr_q;
        end else begin
            grant = req1_val;
        end
`else
        grant = ~req0_val & req1_val;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            ptr_q    <= 1'b1;
            fn_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            fn_q     <= fn_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        fn_d     = fn_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (any_val) begin
                    owner_d = grant;
                    fn_d    = grant ? req1_msg_fn : req0_msg_fn;
                    a_d     = grant ? req1_msg_a  : req0_msg_a;
                    b_d     = grant ? req1_msg_b  : req0_msg_b;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (divreq_rdy) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (divresp_val) begin
                    result_d = divresp_msg_result;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (owner_q ? resp1_rdy : resp0_rdy) begin
                    ptr_d   = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_rdy    = 1'b0;
        req1_rdy    = 1'b0;
        resp0_val   = 1'b0;
        resp1_val   = 1'b0;
        divreq_val  = 1'b0;
        divresp_rdy = 1'b0;
        case (state_q)
            IDLE: begin
                req0_rdy = req0_val & ~grant;
                req1_rdy = req1_val &  grant;
            end
            ISSUE: divreq_val  = 1'b1;
            WAIT:  divresp_rdy = 1'b1;
            RESP: begin
                resp0_val = ~owner_q;
                resp1_val =  owner_q;
            end
            default: ;
        endcase
    end

    // Message buses come straight from registers, so they stay stable under stalls
    assign divreq_msg_fn    = fn_q;
    assign divreq_msg_a     = a_q;
    assign divreq_msg_b     = b_q;
    assign resp0_msg_result = result_q;
    assign resp1_msg_result = result_q;

endmodule

// File: tb/tb_imuldiv_div_arbiter.sv
// tb/tb_imuldiv_div_arbiter.sv - directed self-checking bench for imuldiv_div_arbiter
module tb_imuldiv_div_arbiter;

    localparam int W = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req0_msg_fn = 1'b0, req1_msg_fn = 1'b0;
    logic [W-1:0]    req0_msg_a = '0, req0_msg_b = '0, req1_msg_a = '0, req1_msg_b = '0;
    logic            req0_val = 1'b0, req1_val = 1'b0;
    logic            req0_rdy, req1_rdy;
    logic [2*W-1:0]  resp0_msg_result, resp1_msg_result;
    logic            resp0_val, resp1_val;
    logic            resp0_rdy = 1'b0, resp1_rdy = 1'b0;
    logic            divreq_msg_fn;
    logic [W-1:0]    divreq_msg_a, divreq_msg_b;
    logic            divreq_val;
    logic            divreq_rdy = 1'b0;
    logic [2*W-1:0]  divresp_msg_result = '0;
    logic            divresp_val = 1'b0;
    logic            divresp_rdy;

    int total = 0;
    int bad   = 0;
    int n_div = 0, n_acc0 = 0, n_acc1 = 0;
    int snap_a, snap_b, snap_d;

    imuldiv_div_arbiter #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset),
        .req0_msg_fn(req0_msg_fn), .req0_msg_a(req0_msg_a), .req0_msg_b(req0_msg_b),
        .req0_val(req0_val), .req0_rdy(req0_rdy),
        .resp0_msg_result(resp0_msg_result), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
        .req1_msg_fn(req1_msg_fn), .req1_msg_a(req1_msg_a), .req1_msg_b(req1_msg_b),
        .req1_val(req1_val), .req1_rdy(req1_rdy),
        .resp1_msg_result(resp1_msg_result), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
        .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
        .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
        .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val),
        .divresp_rdy(divresp_rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (divreq_val && divreq_rdy) n_div  <= n_div + 1;
        if (req0_val && req0_rdy)     n_acc0 <= n_acc0 + 1;
        if (req1_val && req1_rdy)     n_acc1 <= n_acc1 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete operation; caller sets request vals/messages beforehand.
    // stall: cycles with divreq_rdy low in ISSUE; bp: cycles with resp rdy low in RESP;
    // hold: keep the winner's val asserted; late1: raise req1_val during backpressure.
    task automatic run_op(input int p, input logic fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] res, input int stall, input int bp,
                          input bit hold, input bit late1, input string tag);
        int n;
        n = 0;
        while (!(req0_rdy || req1_rdy) && n < 20) begin
            tick();
            n++;
        end
        chk($sformatf("%s.grant", tag), {req1_rdy, req0_rdy}, (p == 0) ? 2'b01 : 2'b10);
        tick();
        if (!hold) begin
            if (p == 0) req0_val = 1'b0;
            else        req1_val = 1'b0;
        end
        #1;
        chk($sformatf("%s.issue_val", tag), {divreq_val, req1_rdy, req0_rdy}, 3'b100);
        chk($sformatf("%s.issue_fn", tag), divreq_msg_fn, fn);
        chk($sformatf("%s.issue_ab", tag), {divreq_msg_a, divreq_msg_b}, {a, b});
        for (int i = 0; i < stall; i++) begin
            tick();
            chk($sformatf("%s.stall%0d", tag, i), {divreq_val, divreq_msg_fn, divreq_msg_a, divreq_msg_b},
                {1'b1, fn, a, b});
        end
        divreq_rdy = 1'b1;
        tick();
        divreq_rdy = 1'b0;
        #1;
        chk($sformatf("%s.wait", tag), {divreq_val, divresp_rdy}, 2'b01);
        tick();
        divresp_val = 1'b1;
        divresp_msg_result = res;
        tick();
        divresp_val = 1'b0;
        divresp_msg_result = '0;
        #1;
        chk($sformatf("%s.resp_val", tag), {resp1_val, resp0_val}, (p == 0) ? 2'b01 : 2'b10);
        chk($sformatf("%s.result", tag), (p == 0) ? resp0_msg_result : resp1_msg_result, res);
        for (int i = 0; i < bp; i++) begin
            if (late1 && i == 0) req1_val = 1'b1;
            tick();
            chk($sformatf("%s.bp%0d", tag, i), {resp1_val, resp0_val, req1_rdy, req0_rdy},
                (p == 0) ? 4'b0100 : 4'b1000);
            chk($sformatf("%s.bp_res%0d", tag, i), (p == 0) ? resp0_msg_result : resp1_msg_result, res);
        end
        if (p == 0) resp0_rdy = 1'b1;
        else        resp1_rdy = 1'b1;
        tick();
        resp0_rdy = 1'b0;
        resp1_rdy = 1'b0;
        #1;
        chk($sformatf("%s.done", tag), {resp1_val, resp0_val}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        reset = 1'b1;
        tick();
        tick();
        chk("reset.ctl", {req0_rdy, req1_rdy, resp0_val, resp1_val, divreq_val, divresp_rdy, divreq_msg_fn}, 7'd0);
        chk("reset.ab", {divreq_msg_a, divreq_msg_b}, 64'd0);
        chk("reset.res", resp0_msg_result, 64'd0);
        reset = 1'b0;
        tick();
        chk("idle.no_rdy", {req1_rdy, req0_rdy}, 2'b00);

        // Port 0 alone: 100 / 7 unsigned
        snap_a = n_acc0;
        req0_msg_fn = 1'b0; req0_msg_a = 32'd100; req0_msg_b = 32'd7; req0_val = 1'b1;
        #1;
        run_op(0, 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 0, 0, 0, 0, "p0");
        chk("p0.one_accept", n_acc0 - snap_a, 1);

        // Port 1 alone: -7 / 2 signed
        req1_msg_fn = 1'b1; req1_msg_a = 32'hFFFFFFF9; req1_msg_b = 32'd2; req1_val = 1'b1;
        #1;
        run_op(1, 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 0, 0, 0, 0, "p1");

        // Both ports hold val for four operations
        snap_b = n_acc1;
        req0_msg_fn = 1'b0; req0_msg_a = 32'd20; req0_msg_b = 32'd6; req0_val = 1'b1;
        req1_msg_fn = 1'b0; req1_msg_a = 32'd30; req1_msg_b = 32'd4; req1_val = 1'b1;
        #1;
`ifdef IMULDIV_DIV_ARBITER_RR_EN
        run_op(0, 1'b0, 32'd20, 32'd6, 64'h00000002_00000003, 0, 0, 1, 0, "rr0");
        run_op(1, 1'b0, 32'd30, 32'd4, 64'h00000002_00000007, 0, 0, 1, 0, "rr1");
        run_op(0, 1'b0, 32'd20, 32'd6, 64'h00000002_00000003, 0, 0, 1, 0, "rr2");
        run_op(1, 1'b0, 32'd30, 32'd4, 64'h00000002_00000007, 0, 0, 1, 0, "rr3");
        req0_val = 1'b0; req1_val = 1'b0;
        chk("rr.p1_accepts", n_acc1 - snap_b, 2);
`else
        run_op(0, 1'b0, 32'd20, 32'd6, 64'h00000002_00000003, 0, 0, 1, 0, "fp0");
        run_op(0, 1'b0, 32'd20, 32'd6, 64'h00000002_00000003, 0, 0, 1, 0, "fp1");
        run_op(0, 1'b0, 32'd20, 32'd6, 64'h00000002_00000003, 0, 0, 1, 0, "fp2");
        run_op(0, 1'b0, 32'd20, 32'd6, 64'h00000002_00000003, 0, 0, 1, 0, "fp3");
        req0_val = 1'b0; req1_val = 1'b0;
        chk("fp.p1_starved", n_acc1 - snap_b, 0);
`endif
        #1;
        tick();
        chk("fair.idle", {req1_rdy, req0_rdy, divreq_val}, 3'b000);

        // Response backpressure 5 cycles; port 1 arrives meanwhile and must wait
        req0_msg_fn = 1'b0; req0_msg_a = 32'd77; req0_msg_b = 32'd10; req0_val = 1'b1;
        req1_msg_fn = 1'b0; req1_msg_a = 32'd50; req1_msg_b = 32'd5;
        #1;
        run_op(0, 1'b0, 32'd77, 32'd10, 64'h00000007_00000007, 0, 5, 0, 1, "bp");
        run_op(1, 1'b0, 32'd50, 32'd5, 64'h00000000_0000000A, 0, 0, 0, 0, "bp_late1");

        // Divider stalls 3 cycles in ISSUE
        snap_d = n_div;
        req0_msg_fn = 1'b1; req0_msg_a = 32'hDEADBEEF; req0_msg_b = 32'h00001234; req0_val = 1'b1;
        #1;
        run_op(0, 1'b1, 32'hDEADBEEF, 32'h00001234, 64'h12345678_9ABCDEF0, 3, 0, 0, 0, "stall");
        chk("stall.one_div_txn", n_div - snap_d, 1);

        // Reset during WAIT
        req0_msg_fn = 1'b0; req0_msg_a = 32'd123; req0_msg_b = 32'd3; req0_val = 1'b1;
        #1;
        chk("rst.accept", req0_rdy, 1'b1);
        tick();
        req0_val = 1'b0;
        divreq_rdy = 1'b1;
        tick();
        divreq_rdy = 1'b0;
        #1;
        chk("rst.in_wait", divresp_rdy, 1'b1);
        reset = 1'b1;
        tick();
        chk("rst.ctl", {req0_rdy, req1_rdy, resp0_val, resp1_val, divreq_val, divresp_rdy}, 6'd0);
        chk("rst.msgs", {divreq_msg_a, divreq_msg_b}, 64'd0);
        reset = 1'b0;
        req1_msg_fn = 1'b0; req1_msg_a = 32'd9; req1_msg_b = 32'd4; req1_val = 1'b1;
        #1;
        run_op(1, 1'b0, 32'd9, 32'd4, 64'h00000001_00000002, 0, 0, 0, 0, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
